// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single-port data memory between the arm core (port 0)
// and a secondary master (port 1). Single-beat reads/writes, req/gnt handshake,
// read data returned one cycle after grant.
// Optional build macro DRAM_ARB_RR_EN: round-robin on contention instead of
// fixed priority with the MAX_HOLD starvation guard.
module dram_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    // port 0 (arm core)
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    // port 1 (loader / DMA)
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    // dram side
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Last-granted-owner states
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       grant0;
    logic       grant1;
    logic       rd_pend;
    logic       rd_owner;

`ifndef DRAM_ARB_RR_EN
    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] hold_cnt;
`endif

    // Arbitration: at most one grant, only to a requesting port, none in reset
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (m0_req && m1_req) begin
`ifdef DRAM_ARB_RR_EN
                grant1 = (state == OWN0);
`else
                grant1 = (hold_cnt == HOLD_MAX);
`endif
                grant0 = !grant1;
            end else begin
                grant0 = m0_req;
                grant1 = m1_req;
            end
        end
    end

    assign m0_gnt = grant0;
    assign m1_gnt = grant1;

    // Granted port drives the dram bus in its grant cycle; idle bus is all zero
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (grant0) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_we    = m0_we;
        end else if (grant1) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_we    = m1_we;
        end
    end

    // Next owner state from this cycle's grant
    always_comb begin
        state_next = IDLE;
        if (grant0) begin
            state_next = OWN0;
        end else if (grant1) begin
            state_next = OWN1;
        end
    end

    // Owner state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pending read return: set by a read grant, consumed the following cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= (grant0 && !m0_we) || (grant1 && !m1_we);
        end
    end

    // The owner state already records who was granted last cycle, so the read
    // owner is taken from it rather than kept in a second flop.
    assign rd_owner  = (state == OWN1);
    assign m0_rvalid = rd_pend && !rd_owner;
    assign m1_rvalid = rd_pend && rd_owner;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

`ifndef DRAM_ARB_RR_EN
    // Consecutive port-0 grants while port 1 waits; saturates at MAX_HOLD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (grant1 || !m1_req) begin
            hold_cnt <= '0;
        end else if (grant0 && (hold_cnt != HOLD_MAX)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`endif

    a_single_grant: assert property (@(posedge clk) disable iff (reset) !(m0_gnt && m1_gnt));
    a_gnt_needs_req: assert property (@(posedge clk) disable iff (reset)
                                      (!m0_gnt || m0_req) && (!m1_gnt || m1_req));

endmodule

// File: tb/tb_dram_arbiter.sv
`timescale 1ns/1ps
module tb_dram_arbiter;

    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    always #5 clk = ~clk;

    dram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0000_0111;
    endfunction

    // Synchronous dram: write on edge, read data one cycle after address
    logic        dram_init = 1'b1;
    logic [31:0] dram [16];
    always @(posedge clk) begin
        if (dram_init) begin
            for (int i = 0; i < 16; i++) dram[i] <= init_val(i);
        end else if (mem_we) begin
            dram[mem_addr[5:2]] <= mem_wdata;
        end
        mem_rdata <= dram[mem_addr[5:2]];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Stimulus: one outstanding transaction per master
    logic        t_req [2];
    logic        t_we  [2];
    logic [31:0] t_addr[2];
    logic [31:0] t_wdata[2];

    // Reference model
    logic [31:0] shadow [16];
    int          streak;      // port-0 grants in a row while port 1 waited
    int          last_g;      // -1 none, 0 / 1 port granted last cycle
    bit          pv [2];      // expected rvalid this cycle
    logic [31:0] pd [2];      // expected rdata this cycle
    int          g_now;
    int          dut_g;

    task automatic apply();
        m0_req = t_req[0]; m0_we = t_we[0]; m0_addr = t_addr[0]; m0_wdata = t_wdata[0];
        m1_req = t_req[1]; m1_we = t_we[1]; m1_addr = t_addr[1]; m1_wdata = t_wdata[1];
    endtask

    task automatic new_txn(input int p, input logic we, input logic [31:0] addr, input logic [31:0] data);
        t_req[p] = 1'b1; t_we[p] = we; t_addr[p] = addr; t_wdata[p] = data;
    endtask

    task automatic rand_txn(input int p, input bit rd_only);
        new_txn(p, rd_only ? 1'b0 : 1'($urandom_range(0, 1)),
                32'h40 + 32'(4 * $urandom_range(0, 15)), $urandom);
    endtask

    task automatic model_reset();
        streak = 0; last_g = -1;
        pv[0] = 0; pv[1] = 0;
        t_req[0] = 1'b0; t_req[1] = 1'b0;
    endtask

    function automatic int predict();
        if (t_req[0] && t_req[1]) begin
`ifdef DRAM_ARB_RR_EN
            return (last_g == 0) ? 1 : 0;
`else
            return (streak >= MAX_HOLD) ? 1 : 0;
`endif
        end
        if (t_req[0]) return 0;
        if (t_req[1]) return 1;
        return -1;
    endfunction

    task automatic cycle_check();
        int g;
        @(negedge clk);
        g = predict();
        g_now = g;
        dut_g = m0_gnt ? 0 : (m1_gnt ? 1 : -1);
        check("m0_gnt", 32'(m0_gnt), 32'(g == 0));
        check("m1_gnt", 32'(m1_gnt), 32'(g == 1));
        check("mem_we", 32'(mem_we), (g >= 0) ? 32'(t_we[g]) : 32'd0);
        check("mem_addr", mem_addr, (g >= 0) ? t_addr[g] : 32'd0);
        if (g >= 0 && t_we[g]) check("mem_wdata", mem_wdata, t_wdata[g]);
        check("m0_rvalid", 32'(m0_rvalid), 32'(pv[0]));
        check("m1_rvalid", 32'(m1_rvalid), 32'(pv[1]));
        if (pv[0]) check("m0_rdata", m0_rdata, pd[0]);
        if (pv[1]) check("m1_rdata", m1_rdata, pd[1]);
    endtask

    task automatic cycle_update();
        int g;
        g = g_now;
        @(posedge clk);
        if (g == 1 || !t_req[1]) streak = 0;
        else if (g == 0 && streak < MAX_HOLD) streak++;
        last_g = g;
        pv[0] = 0; pv[1] = 0;
        if (g >= 0) begin
            if (t_we[g]) begin
                shadow[t_addr[g][5:2]] = t_wdata[g];
            end else begin
                pv[g] = 1;
                pd[g] = shadow[t_addr[g][5:2]];
            end
            t_req[g] = 1'b0;
        end
        #1;
    endtask

    task automatic cycle();
        apply();
        cycle_check();
        cycle_update();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        apply();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
        t_we[0] = 0; t_we[1] = 0; t_addr[0] = 0; t_addr[1] = 0; t_wdata[0] = 0; t_wdata[1] = 0;
        model_reset();
        apply();
        repeat (2) @(posedge clk);
        #1;
        dram_init = 1'b0;

        // 1: request held during reset gets no grant; granted on release
        new_txn(0, 1'b0, 32'h48, 32'h0);
        apply();
        @(negedge clk);
        check("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        check("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        check("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();
        check("rel_m0_gnt_seen", 32'(dut_g), 32'd0);
        t_req[0] = 1'b0;
        cycle();

        // 2: write then read of same address by the other port
        new_txn(0, 1'b1, 32'h64, 32'd7);
        cycle();
        new_txn(1, 1'b0, 32'h64, 32'd0);
        cycle();
        apply();
        cycle_check();
        check("t2_m1_rvalid", 32'(m1_rvalid), 32'd1);
        check("t2_m1_rdata", m1_rdata, 32'd7);
        cycle_update();

        // 6: back-to-back reads from both ports
        new_txn(0, 1'b0, 32'h60, 32'd0);
        cycle();
        new_txn(1, 1'b0, 32'h64, 32'd0);
        apply();
        cycle_check();
        check("t6_m0_rvalid", 32'(m0_rvalid), 32'd1);
        check("t6_m0_rdata", m0_rdata, init_val(8));
        cycle_update();
        apply();
        cycle_check();
        check("t6_m1_rvalid", 32'(m1_rvalid), 32'd1);
        check("t6_m1_rdata", m1_rdata, 32'd7);
        cycle_update();

        // 3/4: continuous contention grant pattern
        do_reset();
        for (int k = 0; k < 12; k++) begin
            if (!t_req[0]) rand_txn(0, 1'b1);
            if (!t_req[1]) rand_txn(1, 1'b1);
            cycle();
`ifdef DRAM_ARB_RR_EN
            check("rr_pattern", 32'(dut_g), 32'(k % 2));
`else
            check("fp_pattern", 32'(dut_g), 32'(((k % (MAX_HOLD + 1)) == MAX_HOLD) ? 1 : 0));
`endif
        end
        cycle();
        t_req[0] = 1'b0; t_req[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rand_txn(1, 1'b1);
            cycle();
            check("m1_only", 32'(dut_g), 32'd1);
        end
        cycle();

        // 5: reset asserted between read grant and data return
        do_reset();
        new_txn(0, 1'b0, 32'h60, 32'd0);
        apply();
        cycle_check();
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        apply();
        check("t5_rvalid_after_edge", 32'(m0_rvalid), 32'd0);
        @(negedge clk);
        check("t5_rvalid_in_reset", 32'(m0_rvalid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();
        check("t5_rvalid_after_release", 32'(m0_rvalid), 32'd0);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!t_req[p] && $urandom_range(0, 9) < 7) rand_txn(p, 1'b0);
            end
            cycle();
        end
        t_req[0] = 1'b0; t_req[1] = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
